// File: rtl/pe_sched_pkg.sv
// Shared types and defaults for the PE job scheduler: FSM states, pipeline tag and
// result FIFO entry layouts.
package pe_sched_pkg;

  localparam int DIM_DEF        = 4;
  localparam int PE_LAT_DEF     = 4;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int IDX_W_PKG      = $clog2(DIM_DEF);

  typedef logic [IDX_W_PKG-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic valid;
    idx_t row;
    idx_t col;
  } res_tag_t;

  typedef struct packed {
    idx_t        row;
    idx_t        col;
    logic [31:0] data;
  } res_entry_t;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pe_sched_if.sv
// Scheduler bus: operand selects and result input on the PE side, plus the
// valid/ready result stream towards the consumer.
interface pe_sched_if #(
  parameter int IDX_W = $clog2(pe_sched_pkg::DIM_DEF)
) ();

  logic             pe_en;
  logic [IDX_W-1:0] op_row;
  logic [IDX_W-1:0] op_col;
  logic [31:0]      pe_c;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_row;
  logic [IDX_W-1:0] res_col;
  logic [31:0]      res_data;

  modport master (
    output pe_en, op_row, op_col, res_valid, res_row, res_col, res_data,
    input  pe_c, res_ready
  );

  modport slave (
    input  pe_en, op_row, op_col, res_valid, res_row, res_col, res_data,
    output pe_c, res_ready
  );

endinterface

// File: rtl/pe_sched_fifo.sv
// First-word-fall-through result FIFO; head is presented combinationally from storage
// and reads as zero while empty. Push and pop may coincide at any fill level.
module pe_sched_fifo
  import pe_sched_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  res_entry_t       push_entry,
  input  logic             pop,
  output res_entry_t       head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  res_entry_t       mem_q [DEPTH];
  res_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign count  = count_q;
  assign head   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop));

endmodule

// File: rtl/pe_job_scheduler.sv
// Sequences one DIM x DIM matrix-product job over a single pipelined PE, credit-throttled
// against the result FIFO. Optional PE_SCHED_PERF_EN adds the stall_cnt port.
//
// state | meaning
// IDLE  | waiting for start; op selects parked at (0,0)
// ISSUE | one operand pair per cycle while credits remain, bubble otherwise
// DRAIN | all pairs issued; waiting for tag pipe and FIFO to empty
// DONE  | single-cycle done pulse, then back to IDLE
module pe_job_scheduler
  import pe_sched_pkg::*;
#(
  parameter int DIM        = DIM_DEF,
  parameter int PE_LAT     = PE_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int IDX_W      = $clog2(DIM)
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
`ifdef PE_SCHED_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  pe_sched_if.master  bus
);

  localparam int CRED_W = credit_w(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

  if (FIFO_DEPTH < PE_LAT) begin : g_depth_chk
    $error("pe_job_scheduler: FIFO_DEPTH must be >= PE_LAT");
  end
  if (IDX_W > IDX_W_PKG) begin : g_idx_chk
    $error("pe_job_scheduler: DIM exceeds the index width of pe_sched_pkg");
  end

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  op_row_q, op_row_d;
  logic [IDX_W-1:0]  op_col_q, op_col_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  res_tag_t          tag_q [PE_LAT];
  res_tag_t          tag_d [PE_LAT];

  logic              issue;
  logic              start_acc;
  logic              pipe_busy;
  logic              pop;
  logic              fifo_push;
  logic              fifo_empty;
  logic              fifo_drained;
  logic [CRED_W-1:0] fifo_count;
  res_entry_t        push_entry;
  res_entry_t        head;

  always_comb begin
    state_d   = state_q;
    op_row_d  = op_row_q;
    op_col_d  = op_col_q;
    issue     = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ISSUE;
          op_row_d  = '0;
          op_col_d  = '0;
        end
      end
      ISSUE: begin
        if (credits_q != '0) begin
          issue = 1'b1;
          if (op_col_q == IDX_LAST) begin
            op_col_d = '0;
            if (op_row_q == IDX_LAST) begin
              op_row_d = '0;
              state_d  = DRAIN;
            end else begin
              op_row_d = op_row_q + IDX_W'(1);
            end
          end else begin
            op_col_d = op_col_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!pipe_busy && fifo_drained) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage PE_LAT-1 lines up with pe_c for the pair issued PE_LAT cycles earlier.
  always_comb begin
    tag_d[0] = '{valid: issue, row: idx_t'(op_row_q), col: idx_t'(op_col_q)};
    for (int i = 1; i < PE_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    pipe_busy = 1'b0;
    for (int i = 0; i < PE_LAT; i++) begin
      pipe_busy = pipe_busy | tag_q[i].valid;
    end
  end

  always_comb begin
    fifo_push  = tag_q[PE_LAT-1].valid;
    push_entry = '{row: tag_q[PE_LAT-1].row, col: tag_q[PE_LAT-1].col, data: bus.pe_c};
  end

  always_comb begin
    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!issue && pop) begin
      credits_d = credits_q + CRED_W'(1);
    end
  end

  // Looking through a pop of the final entry lets done follow the last pop directly.
  assign fifo_drained = fifo_empty || ((fifo_count == CRED_W'(1)) && pop);
  assign pop          = !fifo_empty && bus.res_ready;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_row_q  <= '0;
      op_col_q  <= '0;
      credits_q <= CRED_W'(FIFO_DEPTH);
      tag_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      op_row_q  <= op_row_d;
      op_col_q  <= op_col_d;
      credits_q <= credits_d;
      tag_q     <= tag_d;
    end
  end

  pe_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (reset_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.pe_en     = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.op_row    = op_row_q;
  assign bus.op_col    = op_col_q;
  assign bus.res_valid = !fifo_empty;
  assign bus.res_row   = IDX_W'(head.row);
  assign bus.res_col   = IDX_W'(head.col);
  assign bus.res_data  = head.data;

`ifdef PE_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      stall_cnt_d = '0;
    end else if ((state_q == ISSUE) && (credits_q == '0)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/pe_job_scheduler.md
Name: pe_job_scheduler

Overview:
- Sequences one DIM x DIM matrix-product job over a single PE dot-product datapath.
- Issues row/column operand selects one pair per cycle to the external operand buffer, which drives the PE's A/B buses.
- Tracks the PE's fixed pipeline latency with a tag shift register and captures each result into an internal result FIFO.
- Streams results out with a valid/ready handshake; issue is credit-throttled so the PE pipeline never needs to stall.

Parameters:
- DIM, 4, matrix dimension; job = DIM*DIM results, row-major (row outer, col inner)
- PE_LAT, 4, cycles from issue (operand select valid at PE input) to pe_c valid
- FIFO_DEPTH, 8, result FIFO entries; must be >= PE_LAT (elaboration error otherwise)
- IDX_W, $clog2(DIM), width of row/col index

Ports:
- CLK  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after last result leaves FIFO
- pe_en  out  1  PE enable; high for whole job (PE restarts its pipeline when en drops)
- op_row  out  IDX_W  A-row select for operand buffer
- op_col  out  IDX_W  B-column select for operand buffer
- pe_c  in  32  PE result
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_row  out  IDX_W  row of head result
- res_col  out  IDX_W  column of head result
- res_data  out  32  head result value

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, pe_en=0, op_row=op_col=0, res_valid=0, res_row=res_col=0, res_data=0; FIFO empty, tag pipe cleared, credits=FIFO_DEPTH.
- States: IDLE -> ISSUE on start; ISSUE -> DRAIN after last pair issued; DRAIN -> DONE when tag pipe empty and FIFO empty; DONE -> IDLE after 1 cycle (done=1 there).
- pe_en=1 in ISSUE and DRAIN, 0 elsewhere.
- ISSUE: issue occurs in a cycle iff credits>0. On issue, {1,op_row,op_col} enters the tag pipe and credits decrement; then op_col increments, wrapping to 0 with op_row incrementing.
- No credit: a bubble tag {0,-,-} enters; op_row/op_col hold.
- Tag pipe: PE_LAT stages. Tag at stage PE_LAT-1 with valid=1 pushes {row,col,pe_c} into the FIFO that cycle.
- Credits: increment on FIFO pop (res_valid && res_ready). Simultaneous issue and pop leaves credits unchanged. Credits never exceed FIFO_DEPTH, so the FIFO never overflows; push on full is an assertion error.
- FIFO is first-word-fall-through: res_* reflect the head combinationally from storage. Pop and push in the same cycle are allowed at any fill level.
- start while busy is ignored.
- Reset mid-job aborts: all state, including in-flight tags and FIFO contents, is discarded.
- Counters wrap at DIM-1. Last issue is row=col=DIM-1. Job length DIM*DIM is exact.
- Arithmetic: index counters IDX_W bits, credits $clog2(FIFO_DEPTH+1) bits. pe_c passes through unmodified (signed 32, no saturation).

Optional Feature:
- Macro PE_SCHED_PERF_EN.
- Defined: adds out port stall_cnt [31:0] = number of ISSUE-state cycles with credits==0 in the current/last job. Cleared on start acceptance; holds after done; reset 0.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package pe_sched_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), result tag struct {valid,row,col}, result entry struct {row,col,data}, DIM/PE_LAT defaults.
- One sub-module: pe_sched_fifo (parameterised FWFT FIFO, depth FIFO_DEPTH, entry type from package).

Test Plan:
- Reset then start, res_ready=1 constantly, pe_c model = PE_LAT-delayed f(row,col)=row*16+col -> 16 results in order (0,0)..(3,3) with data 0..51; done pulses 1 cycle after the last pop; no bubble issues.
- res_ready=0 throughout -> exactly 8 issues, then credits=0 and op selects hold; FIFO holds 8 entries; releasing res_ready completes all 16 in order.
- res_ready toggling 1010… -> all 16 results correct and ordered; no FIFO overflow assertion fires.
- Second start pulse while busy -> ignored; exactly 16 results and one done.
- reset_n low at issue #9 -> all outputs reach reset values asynchronously; a following start produces a clean 16-result job from (0,0).
- PE_SCHED_PERF_EN defined, res_ready=0 for 20 cycles after start -> stall_cnt = cycles in ISSUE with zero credit (12 with PE_LAT=4, FIFO_DEPTH=8); stall_cnt cleared on next start.
